// File: rtl/bram_stream_reader_if.sv
// Valid/ready coefficient stream with end-of-burst marker.
// The master drives data/valid/last; the slave returns ready.
interface bram_stream_reader_if #(
  parameter int DATA_W = 12
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Burst read sequencer for the coefficient BRAM: issues addresses and streams words out.
// Optional macro BRS_BITREV_EN adds a bitrev input selecting bit-reversed read order.
module bram_stream_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef BRS_BITREV_EN
  input  logic              bitrev,
`endif
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  bram_stream_reader_if.master m
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_m1_q;
  logic [ADDR_W:0]     idx_q;
  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   raddr_d;

  logic                issue_first, issue_run, issue_any, issue_last;
  logic                done_d;

  // p0: address registered toward the BRAM; p1: BRAM output valid
  logic                vld_p0, last_p0;
  logic                vld_p1, last_p1;

  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      occ;
  logic                push, pop;

`ifdef BRS_BITREV_EN
  logic                rev_q;

  function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int k = 0; k < ADDR_W; k++) r[k] = v[ADDR_W-1-k];
    return r;
  endfunction

  assign off = rev_q ? bit_rev(idx_q[ADDR_W-1:0]) : idx_q[ADDR_W-1:0];
`else
  assign off = idx_q[ADDR_W-1:0];
`endif

  // Reads already committed (buffered or still in the BRAM pipe) bound the issue rate
  assign occ  = {1'b0, fifo_count} + (CNT_W+1)'(vld_p0) + (CNT_W+1)'(vld_p1);
  assign push = vld_p1;
  assign pop  = m.m_valid && m.m_ready;

  always_comb begin
    state_d     = state_q;
    issue_first = 1'b0;
    issue_run   = 1'b0;
    issue_last  = 1'b0;
    done_d      = 1'b0;
    raddr_d     = base_q + off;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            issue_first = 1'b1;
            issue_last  = (len == ONE_C);
            raddr_d     = base_addr;
            state_d     = (len == ONE_C) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (occ < DEPTH_C) begin
          issue_run  = 1'b1;
          issue_last = (idx_q == len_m1_q);
          if (idx_q == len_m1_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m.m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_any = issue_first | issue_run;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      raddr      <= '0;
      idx_q      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      done   <= done_d;
      vld_p0 <= issue_any;
      vld_p1 <= vld_p0;
      if (issue_any) raddr <= raddr_d;
      if (issue_first)    idx_q <= ONE_C;
      else if (issue_run) idx_q <= idx_q + ONE_C;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      base_q   <= base_addr;
      len_m1_q <= len - ONE_C;
`ifdef BRS_BITREV_EN
      rev_q    <= bitrev;
`endif
    end
    last_p0 <= issue_last;
    last_p1 <= last_p0;
    if (push) fifo_mem[wr_ptr] <= {last_p1, rdata};
  end

  // Empty buffer presents zeros so outputs are defined straight out of reset
  assign busy      = (state_q != IDLE);
  assign m.m_valid = (fifo_count != '0);
  assign m.m_data  = m.m_valid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
  assign m.m_last  = m.m_valid ? fifo_mem[rd_ptr][DATA_W] : 1'b0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a behavioural BRAM (mem[k] = k + 0x100).
module tb_bram_stream_reader;
  localparam int AW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
`ifdef BRS_BITREV_EN
  logic          bitrev = 1'b0;
`endif

  bram_stream_reader_if #(.DATA_W(DW)) sif ();

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef BRS_BITREV_EN
    .bitrev(bitrev),
`endif
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .raddr(raddr), .rdata(rdata), .m(sif)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = DW'(k + 'h100);
  always @(posedge clk) rdata <= mem[raddr];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rev8(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int k = 0; k < AW; k++) r[k] = v[AW-1-k];
    return r;
  endfunction

  // Reference model state: expected words, burst activity and pending done
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  bit            model_busy = 0;
  bit            done_pend  = 0;
  int            vwait      = 0;
  int            hs_cnt     = 0;
  bit            stall_v    = 0;
  logic [DW-1:0] stall_d;
  logic          stall_l;
  int            ready_mode = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_d.delete(); exp_l.delete();
      model_busy = 0; done_pend = 0; vwait = 0; stall_v = 0;
    end else begin
      chk("fifo_bound", 32'(dut.fifo_count <= 4), 1);
      chk("busy", 32'(busy), 32'(model_busy));
      if (done || done_pend) chk("done", 32'(done), 32'(done_pend));
      done_pend = 0;
      if (vwait > 0) begin
        vwait--;
        if (vwait == 0) chk("first_valid_latency", 32'(sif.m_valid), 1);
      end
      if (stall_v) begin
        chk("stall_valid", 32'(sif.m_valid), 1);
        chk("stall_data", 32'(sif.m_data), 32'(stall_d));
        chk("stall_last", 32'(sif.m_last), 32'(stall_l));
      end
      stall_v = 0;
      if (start && !model_busy) begin
        if (len == 0) begin
          done_pend = 1;
        end else begin
          for (int i = 0; i < int'(len); i++) begin
            logic [AW-1:0] o;
            o = AW'(i);
`ifdef BRS_BITREV_EN
            if (bitrev) o = rev8(o);
`endif
            exp_d.push_back(mem[AW'(base_addr + o)]);
            exp_l.push_back(i == int'(len) - 1);
          end
          model_busy = 1;
          vwait = 3;
        end
      end else if (sif.m_valid && sif.m_ready) begin
        hs_cnt++;
        if (exp_d.size() == 0) begin
          chk("unexpected_word", 32'(sif.m_data), 32'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] ed;
          bit el;
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          chk("m_data", 32'(sif.m_data), 32'(ed));
          chk("m_last", 32'(sif.m_last), 32'(el));
          if (el) begin
            model_busy = 0;
            done_pend = 1;
          end
        end
      end else if (sif.m_valid) begin
        stall_v = 1;
        stall_d = sif.m_data;
        stall_l = sif.m_last;
      end
    end
  end

  // Downstream backpressure: always-ready or random with occasional 10-cycle stalls
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    sif.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) begin
        sif.m_ready = 1'b1;
      end else if (stall_cnt > 0) begin
        sif.m_ready = 1'b0;
        stall_cnt--;
      end else if ($urandom_range(0, 11) == 0) begin
        sif.m_ready = 1'b0;
        stall_cnt = 9;
      end else begin
        sif.m_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic cmd(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!model_busy && exp_d.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int hs0;
    bit got;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_valid", 32'(sif.m_valid), 0);
    chk("rst_data", 32'(sif.m_data), 0);
    chk("rst_last", 32'(sif.m_last), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Sequential burst with exact timing
    cmd(8'h00, 9'd4);
    @(negedge clk);
    chk("t1_raddr0", 32'(raddr), 0);
    chk("t1_valid_n1", 32'(sif.m_valid), 0);
    @(negedge clk);
    chk("t1_valid_n2", 32'(sif.m_valid), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid_run", 32'(sif.m_valid), 1);
      chk("t1_last_pos", 32'(sif.m_last), 32'(k == 3));
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_low", 32'(busy), 0);
    wait_idle();

    // Address wrap
    cmd(8'hFE, 9'd4);
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] ea;
      @(negedge clk);
      ea = AW'(8'hFE + k);
      chk("t2_raddr", 32'(raddr), 32'(ea));
    end
    wait_idle();

    // Random backpressure
    ready_mode = 1;
    cmd(AW'($urandom), 9'd16);
    wait_idle();
    ready_mode = 0;

    // Zero-length command, then start ignored mid-burst
    cmd(8'h33, 9'd0);
    wait_idle();
    cmd(8'h10, 9'd8);
    repeat (2) @(posedge clk);
    cmd(8'h50, 9'd5);
    wait_idle();

    // Reset mid-burst
    hs0 = hs_cnt;
    cmd(8'h40, 9'd10);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs_cnt >= hs0 + 3) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("t5_hs_timeout", 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_rst", 32'(sif.m_valid), 0);
    chk("t5_busy_after_rst", 32'(busy), 0);
    repeat (3) @(posedge clk);
    cmd(8'h20, 9'd2);
    wait_idle();

    // Random bursts under random backpressure
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      cmd(AW'($urandom), 9'($urandom_range(1, 40)));
      wait_idle();
    end
    ready_mode = 0;

    // Whole array once
    cmd(8'h80, 9'd256);
    wait_idle();

`ifdef BRS_BITREV_EN
    bitrev = 1'b1;
    cmd(8'h00, 9'd4);
    bitrev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] ea;
      @(negedge clk);
      ea = rev8(AW'(k));
      chk("t6_raddr", 32'(raddr), 32'(ea));
    end
    wait_idle();
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
